// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a one-cycle-latency instruction memory, presents one
// registered instruction per cycle and handles stall, branch redirect and halt.
module instruction_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [8:0]  branch_offset,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [8:0]  offset,
   output logic [6:0]  immediate,
   output logic [5:0]  nzimm,
   output logic [7:0]  pc_out,
   output logic        instr_valid,
   output logic        halted
);

   typedef enum logic [1:0] {StFill, StRun, StHalt} state_t;

   state_t      state_q, state_d;
   logic [7:0]  fetch_pc_q, fetch_pc_d;
   logic [7:0]  data_pc_q, data_pc_d;
   logic [15:0] instr_q, instr_d;
   logic [7:0]  pc_out_q, pc_out_d;
   logic        valid_q, valid_d;

   logic        advance;
   logic        redirect;
   logic [7:0]  target;

   assign advance  = !(valid_q && stall);
   assign redirect = branch_taken && valid_q && !stall;
   // 9-bit signed offset added to 8-bit pc; truncation gives the mod-256 wrap.
   assign target   = 8'(pc_out_q + branch_offset);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      data_pc_d  = data_pc_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      valid_d    = valid_q;
      imem_addr  = data_pc_q;

      unique case (state_q)
         StFill: begin
            imem_addr  = fetch_pc_q;
            data_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 8'd1;
            state_d    = StRun;
         end
         StRun: begin
            if (redirect) begin
               // Wrong-path data on imem_rdata is dropped; this edge is the bubble.
               imem_addr  = target;
               data_pc_d  = target;
               fetch_pc_d = target + 8'd1;
               valid_d    = 1'b0;
            end else if (advance) begin
               imem_addr = fetch_pc_q;
               instr_d   = imem_rdata;
               pc_out_d  = data_pc_q;
               valid_d   = 1'b1;
               if (imem_rdata[15:12] == 4'hF) begin
                  // Freeze the address pointers so the halt word stays addressed.
                  state_d = StHalt;
               end else begin
                  data_pc_d  = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 8'd1;
               end
            end else begin
               imem_addr = data_pc_q;
            end
         end
         StHalt: begin
            imem_addr = data_pc_q;
            if (!stall) begin
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StFill;
         fetch_pc_q <= 8'h00;
         data_pc_q  <= 8'h00;
         instr_q    <= 16'h0000;
         pc_out_q   <= 8'h00;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         data_pc_q  <= data_pc_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         valid_q    <= valid_d;
      end
   end

   assign instr       = instr_q;
   assign opcode      = instr_q[15:12];
   assign offset      = instr_q[8:0];
   assign immediate   = instr_q[6:0];
   assign nzimm       = instr_q[5:0];
   assign pc_out      = pc_out_q;
   assign instr_valid = valid_q;
   assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous memory model, directed scenarios and a random
// stall/branch phase checked against a program-order reference model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [8:0]  branch_offset;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [8:0]  offset;
   logic [6:0]  immediate;
   logic [5:0]  nzimm;
   logic [7:0]  pc_out;
   logic        instr_valid;
   logic        halted;

   logic [15:0] mem [256];

   int checks   = 0;
   int failures = 0;

   // Reference model: what the consumer should see, in program order.
   logic        m_valid;
   logic        m_halt;
   logic        m_wait;
   logic [7:0]  m_pc;
   logic [7:0]  m_next;
   logic [15:0] m_instr;

   instruction_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_offset(branch_offset),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .opcode       (opcode),
      .offset       (offset),
      .immediate    (immediate),
      .nzimm        (nzimm),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= mem[imem_addr];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_halt  = 1'b0;
      m_wait  = 1'b1;
      m_pc    = 8'h00;
      m_next  = 8'h00;
      m_instr = 16'h0000;
   endtask

   task automatic fill_mem();
      logic [15:0] w;
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'hF) w[15:12] = 4'h7;
         mem[i] = w;
      end
   endtask

   task automatic check_state();
      chk("instr_valid", 16'(instr_valid), 16'(m_valid));
      chk("halted", 16'(halted), 16'(m_halt));
      if (m_valid) begin
         chk("instr", instr, m_instr);
         chk("pc_out", 16'(pc_out), 16'(m_pc));
         chk("opcode", 16'(opcode), 16'(m_instr[15:12]));
         chk("offset", 16'(offset), 16'(m_instr[8:0]));
         chk("immediate", 16'(immediate), 16'(m_instr[6:0]));
         chk("nzimm", 16'(nzimm), 16'(m_instr[5:0]));
      end
   endtask

   // Called just after a rising edge: apply inputs, check address, predict, clock, check.
   task automatic cycle(input logic st, input logic br, input logic [8:0] off);
      logic [7:0] exp_addr;
      stall         = st;
      branch_taken  = br;
      branch_offset = off;
      #1;
      if (m_halt)                   exp_addr = m_pc;
      else if (m_wait)              exp_addr = m_next;
      else if (m_valid && !st && br) exp_addr = m_pc + off[7:0];
      else if (m_valid && st)       exp_addr = m_next;
      else                          exp_addr = m_next + 8'd1;
      chk("imem_addr", 16'(imem_addr), 16'(exp_addr));

      if (m_halt) begin
         if (!st) m_valid = 1'b0;
      end else if (m_wait) begin
         m_wait = 1'b0;
      end else if (m_valid && !st && br) begin
         m_valid = 1'b0;
         m_next  = m_pc + off[7:0];
      end else if (!(m_valid && st)) begin
         m_instr = mem[m_next];
         m_pc    = m_next;
         m_valid = 1'b1;
         m_next  = m_next + 8'd1;
         if (m_instr[15:12] == 4'hF) m_halt = 1'b1;
      end

      @(posedge clk);
      #1;
      check_state();
   endtask

   // Entered just after an edge; asserts reset between edges and releases it after one edge.
   task automatic do_reset();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 9'h000;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", 16'(instr_valid), 16'h0000);
      chk("rst_halted", 16'(halted), 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_pc_out", 16'(pc_out), 16'h0000);
      chk("rst_imem_addr", 16'(imem_addr), 16'h0000);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 9'h000;
      fill_mem();
      mem[0] = 16'h0123;
      mem[1] = 16'h1456;
      mem[2] = 16'h2789;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // First instruction two edges after release, then one per cycle.
      cycle(1'b0, 1'b0, 9'h000);
      chk("fill_valid", 16'(instr_valid), 16'h0000);
      cycle(1'b0, 1'b0, 9'h000);
      chk("first_instr", instr, 16'h0123);
      chk("first_pc", 16'(pc_out), 16'h0000);
      cycle(1'b0, 1'b0, 9'h000);
      chk("second_instr", instr, 16'h1456);

      // Stall at pc 1; a branch during stall is ignored.
      cycle(1'b1, 1'b0, 9'h000);
      cycle(1'b1, 1'b1, 9'h1FD);
      cycle(1'b1, 1'b0, 9'h000);
      chk("stall_addr", 16'(imem_addr), 16'h0002);
      chk("stall_pc", 16'(pc_out), 16'h0001);
      cycle(1'b0, 1'b0, 9'h000);
      chk("post_stall_instr", instr, 16'h2789);
      chk("post_stall_pc", 16'(pc_out), 16'h0002);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 9'h000);
      chk("at_pc5", 16'(pc_out), 16'h0005);

      // Branch back by 3; during the bubble a branch request is ignored.
      cycle(1'b0, 1'b1, 9'h1FD);
      chk("bubble_valid", 16'(instr_valid), 16'h0000);
      cycle(1'b0, 1'b1, 9'h010);
      chk("branch_pc", 16'(pc_out), 16'h0002);
      chk("branch_instr", instr, 16'h2789);

      // Wrap-around: 2 -> FE, FE+4 -> 02, 2 -> FD then sequential through FF to 00.
      cycle(1'b0, 1'b1, 9'h1FC);
      cycle(1'b0, 1'b0, 9'h000);
      chk("pc_fe", 16'(pc_out), 16'h00FE);
      cycle(1'b0, 1'b1, 9'h004);
      cycle(1'b0, 1'b0, 9'h000);
      chk("wrap_target", 16'(pc_out), 16'h0002);
      cycle(1'b0, 1'b1, 9'h1FB);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 9'h000);
      chk("seq_wrap", 16'(pc_out), 16'h0000);

      // Random stall/branch traffic over a halt-free program.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), 9'($urandom));
      end

      // Halt at address 3.
      mem[3] = 16'hF000;
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 9'h000);
      chk("halt_pc", 16'(pc_out), 16'h0003);
      chk("halt_valid", 16'(instr_valid), 16'h0001);
      chk("halt_flag", 16'(halted), 16'h0001);
      cycle(1'b1, 1'b0, 9'h000);
      chk("halt_stall_valid", 16'(instr_valid), 16'h0001);
      cycle(1'b0, 1'b1, 9'h004);
      chk("halt_drop_valid", 16'(instr_valid), 16'h0000);
      for (int i = 0; i < 10; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom));
         chk("halt_hold", 16'(halted), 16'h0001);
      end
      chk("halt_addr", 16'(imem_addr), 16'h0003);

      // Asynchronous reset out of HALT, then refetch from 0.
      do_reset();
      cycle(1'b0, 1'b0, 9'h000);
      cycle(1'b0, 1'b0, 9'h000);
      chk("refetch_instr", instr, 16'h0123);
      chk("refetch_pc", 16'(pc_out), 16'h0000);
      cycle(1'b0, 1'b0, 9'h000);
      chk("refetch_instr2", instr, 16'h1456);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
